// File: rtl/mdu_iter_pkg.sv
// Shared opcode codes and FSM encoding for the iterative multiply/divide unit.
// MADD/MADDU codes are always defined; mdu_iter only honours them under MDU_MADD_EN.
package mdu_iter_pkg;

  localparam logic [4:0] ALUOP_MULT  = 5'h18;
  localparam logic [4:0] ALUOP_MULTU = 5'h19;
  localparam logic [4:0] ALUOP_DIV   = 5'h1A;
  localparam logic [4:0] ALUOP_DIVU  = 5'h1B;
  localparam logic [4:0] ALUOP_MTHI  = 5'h11;
  localparam logic [4:0] ALUOP_MTLO  = 5'h13;
  localparam logic [4:0] ALUOP_MADD  = 5'h1C;
  localparam logic [4:0] ALUOP_MADDU = 5'h1D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_div_core.sv
// One step of an unsigned restoring divider: shift in the next dividend bit,
// subtract the divisor if it fits, and shift the quotient bit in.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    // Bit WIDTH of diff is the borrow: set means the divisor did not fit.
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate opcodes.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OPW-1:0]   aluop_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH);

  mdu_state_t       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] src0_q, src0_d, a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] div_rem, div_quo;

  function automatic logic op_eq(input logic [OPW-1:0] op, input logic [4:0] code);
    return op == OPW'(code);
  endfunction

  function automatic logic is_madd(input logic [OPW-1:0] op);
    return MADD_EN && (op_eq(op, ALUOP_MADD) || op_eq(op, ALUOP_MADDU));
  endfunction

  function automatic logic is_mul(input logic [OPW-1:0] op);
    return op_eq(op, ALUOP_MULT) || op_eq(op, ALUOP_MULTU) || is_madd(op);
  endfunction

  function automatic logic is_signed_op(input logic [OPW-1:0] op);
    return op_eq(op, ALUOP_MULT) || op_eq(op, ALUOP_DIV) ||
           (MADD_EN && op_eq(op, ALUOP_MADD));
  endfunction

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem_i (a_q),
    .quo_i (b_q),
    .div_i (m_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  logic                 s0neg, s1neg;
  logic [WIDTH-1:0]     mag0, mag1;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src0_d  = src0_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    s0neg   = is_signed_op(op_q) && src0_q[WIDTH-1];
    s1neg   = is_signed_op(op_q) && m_q[WIDTH-1];
    mag0    = s0neg ? -src0_q : src0_q;
    mag1    = s1neg ? -m_q : m_q;
    sum     = {1'b0, a_q} + {1'b0, (b_q[0] ? m_q : '0)};
    prod    = {a_q, b_q};

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          if (op_eq(aluop_i, ALUOP_MTHI)) begin
            hi_d = src0_i;
          end else if (op_eq(aluop_i, ALUOP_MTLO)) begin
            lo_d = src0_i;
          end else if (is_mul(aluop_i) || op_eq(aluop_i, ALUOP_DIV) ||
                       op_eq(aluop_i, ALUOP_DIVU)) begin
            op_d    = aluop_i;
            src0_d  = src0_i;
            m_d     = src1_i;
            state_d = ST_PREP;
          end
        end
      end
      ST_PREP: begin
        // m_q still holds raw src1 here; it becomes the multiplicand or divisor.
        a_d    = '0;
        neg_d  = s0neg ^ s1neg;
        rneg_d = s0neg;
        dz_d   = (m_q == '0);
        cnt_d  = CW'(WIDTH - 1);
        if (is_mul(op_q)) begin
          b_d = mag1;
          m_d = mag0;
        end else begin
          b_d = mag0;
          m_d = mag1;
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (is_mul(op_q)) begin
          a_d = sum[WIDTH:1];
          b_d = {sum[0], b_q[WIDTH-1:1]};
        end else begin
          a_d = div_rem;
          b_d = div_quo;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        if (is_mul(op_q)) begin
          if (neg_q) prod = -prod;
          if (is_madd(op_q)) prod = prod + {hi_q, lo_q};
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          hi_d = src0_q;
          lo_d = '1;
        end else begin
          lo_d = neg_q  ? -b_q : b_q;
          hi_d = rneg_q ? -a_q : a_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src0_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src0_q  <= src0_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
